mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - MEM-stage request, data BRAM and board IO signal bundle
interface mem_access_unit_if #(
  parameter int RAM_AW = 14
);
  logic              MEM_MemRead;
  logic              MEM_MemWrite;
  logic              MEM_ioRead;
  logic              MEM_ioWrite;
  logic [31:0]       MEM_ALUResult;
  logic [31:0]       MEM_rs2_v;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [11:0]       switch_in;
  logic [3:0]        key_in;
  logic [15:0]       led_out;
  logic [31:0]       seg_data;
  logic              stall;
  logic [31:0]       load_data;
  logic              load_valid;

  modport slave (
    input  MEM_MemRead, MEM_MemWrite, MEM_ioRead, MEM_ioWrite, MEM_ALUResult, MEM_rs2_v,
    input  ram_rdata, switch_in, key_in,
    output ram_en, ram_we, ram_addr, ram_wdata, led_out, seg_data, stall, load_data, load_valid
  );

  modport master (
    output MEM_MemRead, MEM_MemWrite, MEM_ioRead, MEM_ioWrite, MEM_ALUResult, MEM_rs2_v,
    output ram_rdata, switch_in, key_in,
    input  ram_en, ram_we, ram_addr, ram_wdata, led_out, seg_data, stall, load_data, load_valid
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: BRAM loads with stall, stores, memory-mapped IO
module mem_access_unit #(
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00,
  parameter int          RAM_AW  = 14
) (
  input  logic            clk,
  input  logic            rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       data_q;
  logic [11:0]       switch_meta, switch_sync;
  logic [3:0]        key_meta, key_sync;
  logic [31:0]       io_rdata;

  // IO requests outrank memory requests; a read outranks a write of the same kind
  logic in_io_window, io_wr, mem_rd, mem_wr;
  logic [7:0]        io_word;
  logic [RAM_AW-1:0] ram_word;
  logic              unused_byte_offset;

  assign in_io_window       = (bus.MEM_ALUResult[31:10] == IO_BASE[31:10]);
  assign io_word            = bus.MEM_ALUResult[9:2];
  assign ram_word           = bus.MEM_ALUResult[RAM_AW+1:2];
  assign unused_byte_offset = &{1'b0, bus.MEM_ALUResult[1:0]};
  assign io_wr  = bus.MEM_ioWrite & ~bus.MEM_ioRead;
  assign mem_rd = bus.MEM_MemRead & ~bus.MEM_ioRead & ~bus.MEM_ioWrite;
  assign mem_wr = bus.MEM_MemWrite & ~bus.MEM_MemRead & ~bus.MEM_ioRead & ~bus.MEM_ioWrite;

  always_comb begin
    io_rdata = '0;
    if (in_io_window) begin
      case (io_word)
        8'h1C:   io_rdata = {20'b0, switch_sync};
        8'h1D:   io_rdata = {28'b0, key_sync};
        default: io_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_rd) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_en     = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.stall      = 1'b0;
    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    // Outputs are gated by rst so an abort never leaks a stall or a load_valid
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.MEM_ioRead) begin
            bus.load_data  = io_rdata;
            bus.load_valid = 1'b1;
          end else if (mem_rd) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = ram_word;
            bus.stall    = 1'b1;
          end else if (mem_wr) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = ram_word;
            bus.ram_wdata = bus.MEM_rs2_v;
          end
        end
        RD_WAIT: begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = addr_q;
          bus.stall    = 1'b1;
        end
        RESP: begin
          bus.load_data  = data_q;
          bus.load_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      bus.led_out <= '0;
      bus.seg_data <= '0;
      switch_meta <= '0;
      switch_sync <= '0;
      key_meta    <= '0;
      key_sync    <= '0;
    end else begin
      switch_meta <= bus.switch_in;
      switch_sync <= switch_meta;
      key_meta    <= bus.key_in;
      key_sync    <= key_meta;
      if (state == IDLE && mem_rd) addr_q <= ram_word;
      if (state == RD_WAIT)        data_q <= bus.ram_rdata;
      if (state == IDLE && io_wr && in_io_window) begin
        if (io_word == 8'h18) bus.led_out  <= bus.MEM_rs2_v[15:0];
        if (io_word == 8'h20) bus.seg_data <= bus.MEM_rs2_v;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - vector table, corner sequences and randomized model check for mem_access_unit
module tb_mem_access_unit;

  localparam int RAM_AW = 14;
  localparam int RAM_WORDS = 16384;
  localparam int K_NONE = 0, K_IOR = 1, K_IOW = 2, K_LD = 3, K_ST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.RAM_AW(RAM_AW)) bus ();

  mem_access_unit #(.IO_BASE(32'hFFFFFC00), .RAM_AW(RAM_AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] tb_ram [RAM_WORDS];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) tb_ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= tb_ram[bus.ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [int];
  logic [15:0] led_model = '0;
  logic [31:0] seg_model = '0;
  logic [11:0] sw_model = '0;
  logic [3:0]  key_model = '0;

  typedef struct {
    bit          mr;
    bit          mw;
    bit          ir;
    bit          iw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % RAM_WORDS);
  endfunction

  function automatic bit in_window(input logic [31:0] addr);
    return (addr / 1024) == (32'hFFFFFC00 / 1024);
  endfunction

  function automatic logic [31:0] model_mem(input logic [31:0] addr);
    int w = word_of(addr);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] model_io(input logic [31:0] addr);
    if (!in_window(addr)) return 32'h0;
    case (addr & 32'h3FC)
      32'h70:  return {20'b0, sw_model};
      32'h74:  return {28'b0, key_model};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_idle();
    bus.MEM_MemRead   = 1'b0;
    bus.MEM_MemWrite  = 1'b0;
    bus.MEM_ioRead    = 1'b0;
    bus.MEM_ioWrite   = 1'b0;
    bus.MEM_ALUResult = 32'h0;
    bus.MEM_rs2_v     = 32'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the request bus idle
  task automatic apply(input bit mr, input bit mw, input bit ir, input bit iw,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp, input string tag);
    int kind;
    logic [31:0] w;
    w = 32'(word_of(addr));
    kind = ir ? K_IOR : iw ? K_IOW : mr ? K_LD : mw ? K_ST : K_NONE;
    bus.MEM_MemRead = mr; bus.MEM_MemWrite = mw;
    bus.MEM_ioRead = ir; bus.MEM_ioWrite = iw;
    bus.MEM_ALUResult = addr; bus.MEM_rs2_v = data;
    #3;
    case (kind)
      K_IOR: begin
        chk({tag, ".ior_valid"}, 32'(bus.load_valid), 32'd1);
        chk({tag, ".ior_data"}, bus.load_data, exp);
        chk({tag, ".ior_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, ".ior_ram_en"}, 32'(bus.ram_en), 32'd0);
        @(posedge clk); #1;
      end
      K_IOW: begin
        chk({tag, ".iow_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, ".iow_ram_en"}, 32'(bus.ram_en), 32'd0);
        chk({tag, ".iow_valid"}, 32'(bus.load_valid), 32'd0);
        if (in_window(addr) && (addr & 32'h3FC) == 32'h60) led_model = data[15:0];
        if (in_window(addr) && (addr & 32'h3FC) == 32'h80) seg_model = data;
        @(posedge clk); #1;
      end
      K_LD: begin
        chk({tag, ".ld1_stall"}, 32'(bus.stall), 32'd1);
        chk({tag, ".ld1_ram_en"}, 32'(bus.ram_en), 32'd1);
        chk({tag, ".ld1_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, ".ld1_ram_addr"}, 32'(bus.ram_addr), w);
        chk({tag, ".ld1_valid"}, 32'(bus.load_valid), 32'd0);
        @(posedge clk); #4;
        chk({tag, ".ld2_stall"}, 32'(bus.stall), 32'd1);
        chk({tag, ".ld2_ram_en"}, 32'(bus.ram_en), 32'd1);
        chk({tag, ".ld2_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, ".ld2_ram_addr"}, 32'(bus.ram_addr), w);
        chk({tag, ".ld2_valid"}, 32'(bus.load_valid), 32'd0);
        @(posedge clk); #4;
        chk({tag, ".ld3_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, ".ld3_valid"}, 32'(bus.load_valid), 32'd1);
        chk({tag, ".ld3_data"}, bus.load_data, exp);
        chk({tag, ".ld3_ram_en"}, 32'(bus.ram_en), 32'd0);
        @(posedge clk); #1;
      end
      K_ST: begin
        chk({tag, ".st_ram_en"}, 32'(bus.ram_en), 32'd1);
        chk({tag, ".st_ram_we"}, 32'(bus.ram_we), 32'd1);
        chk({tag, ".st_ram_addr"}, 32'(bus.ram_addr), w);
        chk({tag, ".st_wdata"}, bus.ram_wdata, data);
        chk({tag, ".st_stall"}, 32'(bus.stall), 32'd0);
        ref_mem[int'(w)] = data;
        @(posedge clk); #1;
      end
      default: begin
        chk({tag, ".idle_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, ".idle_ram_en"}, 32'(bus.ram_en), 32'd0);
        chk({tag, ".idle_valid"}, 32'(bus.load_valid), 32'd0);
        chk({tag, ".idle_data"}, bus.load_data, 32'd0);
        @(posedge clk); #1;
      end
    endcase
    drive_idle();
    chk({tag, ".led"}, 32'(bus.led_out), 32'(led_model));
    chk({tag, ".seg"}, bus.seg_data, seg_model);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mr, mw, ir, iw;
    logic [31:0] a, d, e;
    for (int i = 0; i < RAM_WORDS; i++) tb_ram[i] = 32'h0;
    bus.ram_rdata = 32'h0;
    bus.switch_in = 12'h0;
    bus.key_in    = 4'h0;
    drive_idle();

    // Reset must win over live requests
    bus.MEM_MemRead = 1'b1; bus.MEM_ioRead = 1'b1; bus.MEM_ALUResult = 32'hFFFFFC70;
    #2;
    chk("rst.stall", 32'(bus.stall), 32'd0);
    chk("rst.ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst.valid", 32'(bus.load_valid), 32'd0);
    chk("rst.data", bus.load_data, 32'd0);
    chk("rst.led", 32'(bus.led_out), 32'd0);
    chk("rst.seg", bus.seg_data, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b0;

    bus.switch_in = 12'hABC; bus.key_in = 4'h5;
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, "settle");
    sw_model = 12'hABC; key_model = 4'h5;

    vecs.push_back('{0, 1, 0, 0, 32'h00000010, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 32'h00000010, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{0, 0, 0, 1, 32'hFFFFFC60, 32'h0001A5A5, 32'h0});
    vecs.push_back('{0, 0, 0, 1, 32'hFFFFFC80, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{0, 0, 0, 1, 32'hFFFFFC64, 32'h11111111, 32'h0});
    vecs.push_back('{0, 1, 0, 0, 32'h00010010, 32'h00001234, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 32'h00000010, 32'h0,        32'h00001234});
    vecs.push_back('{1, 1, 0, 0, 32'h00000010, 32'h55555555, 32'h00001234});
    vecs.push_back('{1, 0, 0, 0, 32'h00000013, 32'h0,        32'h00001234});
    vecs.push_back('{1, 0, 1, 0, 32'hFFFFFC74, 32'h0,        32'h00000005});
    vecs.push_back('{0, 0, 1, 1, 32'hFFFFFC60, 32'h0000FFFF, 32'h0});
    vecs.push_back('{0, 0, 1, 0, 32'hFFFFFC70, 32'h0,        32'h00000ABC});
    vecs.push_back('{0, 1, 1, 0, 32'h00000000, 32'h77777777, 32'h0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        32'h0});
    vecs.push_back('{0, 1, 0, 0, 32'h00000000, 32'hAAAA0000, 32'h0});
    vecs.push_back('{0, 1, 0, 0, 32'h00000004, 32'hBBBB1111, 32'h0});
    vecs.push_back('{1, 0, 0, 0, 32'h00000000, 32'h0,        32'hAAAA0000});
    vecs.push_back('{1, 0, 0, 0, 32'h00000004, 32'h0,        32'hBBBB1111});
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].mr, vecs[i].mw, vecs[i].ir, vecs[i].iw,
            vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset while in RD_WAIT
    bus.MEM_MemRead = 1'b1; bus.MEM_ALUResult = 32'h10;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rdwait_rst.stall", 32'(bus.stall), 32'd0);
    chk("rdwait_rst.valid", 32'(bus.load_valid), 32'd0);
    chk("rdwait_rst.ram_en", 32'(bus.ram_en), 32'd0);
    chk("rdwait_rst.led", 32'(bus.led_out), 32'd0);
    chk("rdwait_rst.seg", bus.seg_data, 32'd0);
    led_model = '0; seg_model = '0;
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, "post_rst");
    apply(1, 0, 0, 0, 32'h10, 32'h0, 32'h00001234, "post_rst_load");

    // Reset while in RESP
    bus.MEM_MemRead = 1'b1; bus.MEM_ALUResult = 32'h4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("resp_pre.valid", 32'(bus.load_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("resp_rst.valid", 32'(bus.load_valid), 32'd0);
    chk("resp_rst.data", bus.load_data, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, "post_rst2");

    // Two-flop synchronizer latency on a switch change
    bus.switch_in = 12'h123;
    apply(0, 0, 1, 0, 32'hFFFFFC70, 32'h0, 32'h00000ABC, "sync_c0");
    apply(0, 0, 1, 0, 32'hFFFFFC70, 32'h0, 32'h00000ABC, "sync_c1");
    apply(0, 0, 1, 0, 32'hFFFFFC70, 32'h0, 32'h00000123, "sync_c2");
    sw_model = 12'h123;

    for (int n = 0; n < 300; n++) begin
      if (n % 64 == 0) begin
        bus.switch_in = 12'($urandom);
        bus.key_in    = 4'($urandom);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, "rnd_settle");
        sw_model = bus.switch_in; key_model = bus.key_in;
      end
      mr = ($urandom_range(0, 2) == 0);
      mw = ($urandom_range(0, 2) == 0);
      ir = ($urandom_range(0, 4) == 0);
      iw = ($urandom_range(0, 4) == 0);
      d  = $urandom;
      if (ir || iw) begin
        case ($urandom_range(0, 5))
          0: a = 32'hFFFFFC60;
          1: a = 32'hFFFFFC70;
          2: a = 32'hFFFFFC74;
          3: a = 32'hFFFFFC80;
          4: a = 32'hFFFFFC00 | (32'($urandom_range(0, 255)) * 4);
          default: a = 32'($urandom_range(0, 255)) * 4;
        endcase
        a = a | 32'($urandom_range(0, 3));
      end else begin
        a = ($urandom << 16) | (32'($urandom_range(0, 31)) * 4) | 32'($urandom_range(0, 3));
      end
      e = ir ? model_io(a) : (!iw && mr) ? model_mem(a) : 32'h0;
      apply(mr, mw, ir, iw, a, d, e, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
